// File: rtl/rgb_byte_assembler.sv
// Byte-serial R,G,B to 24-bit {B,G,R} pixel assembler with raster tagging.
// Feeds the grayscale converter; valid/ready on both sides.
module rgb_byte_assembler #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480,
    parameter int unsigned XW       = $clog2(H_PIXELS),
    parameter int unsigned YW       = $clog2(V_LINES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    output logic [23:0] color,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sol,
    output logic        out_eol,
    output logic        out_eof,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    phase_e        phase_q, phase_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    r_hold_q, r_hold_d;
    logic [7:0]    g_hold_q, g_hold_d;
    logic [23:0]   color_q, color_d;
    logic          out_valid_q, out_valid_d;
    logic          sol_q, sol_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          sync_err_q, sync_err_d;
    // Short-frame check is suppressed until the first in_sof after reset.
    logic          sof_seen_q, sof_seen_d;
    logic          byte_acc;
    logic          eol_now;

    // B byte may only enter when the output register is free or draining.
    assign in_ready = (phase_q != PH_B) | ~out_valid_q | out_ready;
    assign byte_acc = in_valid & in_ready;
    assign eol_now  = (x_q == X_LAST);

    // Next-state: byte phase, raster counters, holds, output register, resync.
    always_comb begin
        phase_d     = phase_q;
        x_d         = x_q;
        y_d         = y_q;
        r_hold_d    = r_hold_q;
        g_hold_d    = g_hold_q;
        color_d     = color_q;
        out_valid_d = out_valid_q;
        sol_d       = sol_q;
        eol_d       = eol_q;
        eof_d       = eof_q;
        sync_err_d  = sync_err_q;
        sof_seen_d  = sof_seen_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (byte_acc) begin
            if (in_sof) begin
                if (phase_q != PH_R) begin
                    sync_err_d = 1'b1;
                end else if (sof_seen_q && ((x_q != '0) || (y_q != '0))) begin
                    sync_err_d = 1'b1;
                end
                sof_seen_d = 1'b1;
                r_hold_d   = in_data;
                phase_d    = PH_G;
                x_d        = '0;
                y_d        = '0;
            end else begin
                unique case (phase_q)
                    PH_R: begin
                        r_hold_d = in_data;
                        phase_d  = PH_G;
                    end
                    PH_G: begin
                        g_hold_d = in_data;
                        phase_d  = PH_B;
                    end
                    PH_B: begin
                        color_d     = {in_data, g_hold_q, r_hold_q};
                        out_valid_d = 1'b1;
                        sol_d       = (x_q == '0);
                        eol_d       = eol_now;
                        eof_d       = eol_now & (y_q == Y_LAST);
                        phase_d     = PH_R;
                        if (eol_now) begin
                            x_d = '0;
                            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                    default: phase_d = PH_R;
                endcase
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_R;
            x_q         <= '0;
            y_q         <= '0;
            r_hold_q    <= '0;
            g_hold_q    <= '0;
            color_q     <= '0;
            out_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            sync_err_q  <= 1'b0;
            sof_seen_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            x_q         <= x_d;
            y_q         <= y_d;
            r_hold_q    <= r_hold_d;
            g_hold_q    <= g_hold_d;
            color_q     <= color_d;
            out_valid_q <= out_valid_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            sync_err_q  <= sync_err_d;
            sof_seen_q  <= sof_seen_d;
        end
    end

    assign color     = color_q;
    assign out_valid = out_valid_q;
    assign out_sol   = sol_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_rgb_byte_assembler.sv
// Self-checking bench for rgb_byte_assembler on a 4x2 raster.
module tb_rgb_byte_assembler;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 2;
    localparam int unsigned NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [23:0] color;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sol;
    logic        out_eol;
    logic        out_eof;
    logic        sync_err;

    rgb_byte_assembler #(
        .H_PIXELS(H),
        .V_LINES (V)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_ready (in_ready),
        .color    (color),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sol  (out_sol),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes of the current pixel, linear pixel index in frame,
    // and a queue of pixels the DUT owes downstream.
    typedef struct {
        logic [23:0] color;
        logic        sol;
        logic        eol;
        logic        eof;
    } pix_t;

    pix_t        exp_q[$];
    int unsigned n_pend;
    logic [7:0]  pend_r;
    logic [7:0]  pend_g;
    int unsigned pix_idx;
    bit          sof_seen;
    bit          exp_err;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        n_pend   = 0;
        pend_r   = '0;
        pend_g   = '0;
        pix_idx  = 0;
        sof_seen = 1'b0;
        exp_err  = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] d, input logic s);
        pix_t p;
        if (s) begin
            if (n_pend != 0) exp_err = 1'b1;
            else if (sof_seen && pix_idx != 0) exp_err = 1'b1;
            sof_seen = 1'b1;
            pend_r   = d;
            n_pend   = 1;
            pix_idx  = 0;
        end else if (n_pend == 0) begin
            pend_r = d;
            n_pend = 1;
        end else if (n_pend == 1) begin
            pend_g = d;
            n_pend = 2;
        end else begin
            p.color = {d, pend_g, pend_r};
            p.sol   = ((pix_idx % H) == 0);
            p.eol   = ((pix_idx % H) == H - 1);
            p.eof   = (pix_idx == NPIX - 1);
            exp_q.push_back(p);
            pix_idx = (pix_idx + 1) % NPIX;
            n_pend  = 0;
        end
    endfunction

    // One clock: drive, sample at falling edge, check against model, advance model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic ordy,
                       output bit acc);
        bit exp_rdy;
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (n_pend < 2) || (exp_q.size() == 0) || ordy;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check_eq("sync_err", 32'(sync_err), 32'(exp_err));
        if (exp_q.size() != 0) begin
            check_eq("color", 32'(color), 32'(exp_q[0].color));
            check_eq("out_sol", 32'(out_sol), 32'(exp_q[0].sol));
            check_eq("out_eol", 32'(out_eol), 32'(exp_q[0].eol));
            check_eq("out_eof", 32'(out_eof), 32'(exp_q[0].eof));
        end
        acc = v && (in_ready === 1'b1);
        if (out_valid === 1'b1 && ordy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) model_byte(d, s);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic ordy);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cyc(1'b1, d, s, ordy, acc);
        check_eq("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_pix(input logic [23:0] bgr, input logic s, input logic ordy);
        send_byte(bgr[7:0], s, ordy);
        send_byte(bgr[15:8], 1'b0, ordy);
        send_byte(bgr[23:16], 1'b0, ordy);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, ordy, acc);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs checked before any edge.
    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_color", 32'(color), 32'd0);
        check_eq("rst_sync_err", 32'(sync_err), 32'd0);
        check_eq("rst_tags", 32'({out_sol, out_eol, out_eof}), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // First pixel after reset.
        send_pix(24'h302010, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Full back-to-back frame, every byte accepted on first offer.
        do_reset();
        for (int p = 0; p < int'(NPIX); p++) begin
            for (int b = 0; b < 3; b++) begin
                cyc(1'b1, 8'(p * 16 + b), (p == 0 && b == 0), 1'b1, acc);
                check_eq("b2b_accept", 32'(acc), 32'd1);
            end
        end
        idle(2, 1'b1);

        // Backpressure: B held off until downstream drains, then same-cycle handoff.
        do_reset();
        send_pix(24'h302010, 1'b1, 1'b1);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h66, 1'b0, 1'b0, acc);
            check_eq("bp_b_blocked", 32'(acc), 32'd0);
        end
        cyc(1'b1, 8'h66, 1'b0, 1'b1, acc);
        check_eq("bp_b_accept", 32'(acc), 32'd1);
        idle(2, 1'b1);

        // Mid-pixel resync discards the partial pixel.
        do_reset();
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'hBB, 1'b0, 1'b1);
        send_pix(24'h030201, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Short frame then a full frame after resync.
        do_reset();
        for (int p = 0; p < 5; p++) send_pix(24'(32'h100000 + p), (p == 0), 1'b1);
        for (int p = 0; p < int'(NPIX); p++) send_pix(24'(32'h200000 + p), (p == 0), 1'b1);
        idle(2, 1'b1);

        // Reset mid-G with a stalled output pixel and sync_err set.
        do_reset();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_pix(24'h0C0B0A, 1'b1, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        idle(1, 1'b0);
        do_reset();
        send_pix(24'h0F0E0D, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with occasional resyncs and backpressure.
        do_reset();
        send_pix(24'h123456, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(63) == 0),
                ($urandom_range(3) != 0), acc);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_byte_assembler.md
Name: rgb_byte_assembler

Overview:
- Upstream neighbour of the grayscale converter.
- Accepts a byte-serial camera/pixel stream in R, G, B byte order and assembles each 24-bit colour word packed as {B[23:16], G[15:8], R[7:0]}, the packing the grayscale stage consumes.
- Tags every pixel with start-of-line, end-of-line and end-of-frame from internal raster counters.
- Both sides use valid/ready handshakes.

Parameters:
- H_PIXELS, 640, pixels per line (≥2)
- V_LINES, 480, lines per frame (≥2)
- XW, $clog2(H_PIXELS), column counter width
- YW, $clog2(V_LINES), line counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  colour byte
- in_valid  input  1  in_data valid
- in_sof  input  1  qualifies in_data as first R byte of a frame (sampled only with in_valid)
- in_ready  output  1  byte accepted when in_valid & in_ready
- color  output  24  assembled pixel {B,G,R}
- out_valid  output  1  color/tags valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_sol  output  1  pixel is column 0
- out_eol  output  1  pixel is column H_PIXELS-1
- out_eof  output  1  pixel is last of frame (column H_PIXELS-1, line V_LINES-1)
- sync_err  output  1  sticky: in_sof seen mid-pixel or frame resynced early

Behaviour:
- Reset (async on rst_n low):
  - phase=PH_R; x=0; y=0.
  - R/G hold registers = 0.
  - color=0; out_valid=0; out_sol/eol/eof=0; sync_err=0.
  - in_ready drives its combinational value: 1 after reset.
- Byte phase FSM: PH_R -> PH_G -> PH_B -> PH_R. Advances only on an accepted byte.
  - PH_R: capture r_hold.
  - PH_G: capture g_hold.
  - PH_B: load output register.
- in_ready (combinational):
  - 1 in PH_R and PH_G.
  - In PH_B: ~out_valid | out_ready. A B byte may complete a pixel in the same cycle the previous pixel drains.
- Output register loads on an accepted B byte:
  - color <= {in_data, g_hold, r_hold}; out_valid <= 1.
  - out_sol <= (x==0); out_eol <= (x==H_PIXELS-1); out_eof <= out_eol & (y==V_LINES-1).
  - Latency: B byte accepted at edge N -> out_valid high after edge N.
- out_valid clears on out_ready & ~(B byte accepted same cycle).
- color and tags hold stable while out_valid & ~out_ready.
- Raster counters advance on each accepted B byte:
  - x wraps H_PIXELS-1 -> 0 and increments y.
  - y wraps V_LINES-1 -> 0.
- in_sof with an accepted byte:
  - The byte is treated as R of pixel (0,0); phase -> PH_G; x=0; y=0.
  - If phase was not PH_R, the partial pixel is discarded and sync_err is set.
  - If phase was PH_R but (x,y) != (0,0), sync_err is set (short frame). This check does not apply to the first frame after reset.
  - An in_sof byte arriving while in PH_B is accepted only when in_ready is high. in_ready is not overridden by in_sof.
- An already-registered output pixel is never dropped or modified by resync.
- sync_err clears only on reset.
- Reset mid-pixel: all state returns to reset values immediately; the partial pixel is lost.
- Throughput: 1 pixel per 3 accepted bytes. Zero bubbles when out_ready stays high.

Test Plan:
- Reset, then in_sof with bytes 0x10, 0x20, 0x30, out_ready=1 -> one cycle after B accepted: color=0x302010, out_valid=1, out_sol=1, out_eol=0, out_eof=0, sync_err=0.
- Back-to-back: feed a full 4x2 frame (H_PIXELS=4, V_LINES=2) with out_ready=1 -> 8 pixels, no in_ready deassertion, eol on pixels 3 and 7, eof only on pixel 7, sol on pixels 0 and 4.
- Backpressure: out_ready=0 after first pixel; send the next R, G, B -> R and G accepted, in_ready=0 at B, color holds 0x302010; raise out_ready -> B accepted in the same cycle the old pixel drains, next pixel appears the following cycle, no gap in out_valid.
- Mid-pixel resync: send R=0xAA, G=0xBB, then in_sof with R=0x01, G=0x02, B=0x03 -> color=0x030201 with sol=1, sync_err=1, no pixel containing 0xAA/0xBB emitted.
- Short frame: in_sof after 5 of 8 pixels of a 4x2 frame -> sync_err=1, next pixel sol=1, eof on the 8th pixel after resync.
- Async reset asserted mid-PH_G while out_valid=1 -> out_valid, color and sync_err go to 0 without waiting for a clock edge; in_ready=1 after release; next pixel tagged sol=1.
